// File: rtl/mdio_pkg.sv
// MDIO host master shared types and frame constants.
// Clause 45 framing is selected by MDIO_CLAUSE45_EN.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_DONE
  } state_e;

  localparam logic [1:0] ST_C22    = 2'b01;
  localparam logic [1:0] ST_C45    = 2'b00;
  localparam logic [1:0] OP_ADDR   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_RD45   = 2'b11;
  localparam logic [1:0] TA_WR     = 2'b10;

  localparam logic [5:0] PRE_LEN    = 6'd32;
  localparam logic [5:0] HDR_END    = 6'd46;
  localparam logic [5:0] DATA_START = 6'd48;
  localparam logic [6:0] FRAME_LEN  = 7'd64;

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: half-period of CLK_DIV clocks while enabled,
// parked low with the divider cleared when disabled.
module mdio_clk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic mdc_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

  logic [7:0] div_q, div_d;
  logic       mdc_q, mdc_d;
  logic       tc;

  assign tc     = (div_q == DIV_TC);
  assign rise_o = en_i && tc && !mdc_q;
  assign fall_o = en_i && tc && mdc_q;
  assign mdc_o  = mdc_q;

  always_comb begin
    div_d = 8'd0;
    mdc_d = 1'b0;
    if (en_i) begin
      div_d = tc ? 8'd0 : div_q + 8'd1;
      mdc_d = tc ? ~mdc_q : mdc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= 8'd0;
      mdc_q <= 1'b0;
    end else begin
      div_q <= div_d;
      mdc_q <= mdc_d;
    end
  end

endmodule

// File: rtl/mdio_host_master.sv
// MDIO management master behind the EMAC host-bus bridge.
// Define MDIO_CLAUSE45_EN for Clause 45 framing (ST=00, all opcodes).
module mdio_host_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        hostreq,
  input  logic        hostmiimsel,
  input  logic [1:0]  hostopcode,
  input  logic [9:0]  hostaddr,
  input  logic [31:0] hostwrdata,
  output logic [31:0] hostrddata,
  output logic        hostmiimrdy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

`ifdef MDIO_CLAUSE45_EN
  localparam logic [1:0] ST_SEL = ST_C45;
  logic op_ok;
  assign op_ok = 1'b1;
`else
  localparam logic [1:0] ST_SEL = ST_C22;
  logic op_ok;
  assign op_ok = (hostopcode == OP_WRITE) ||
                 (hostopcode == OP_READ);
`endif

  state_e      state_q, state_d;
  logic [5:0]  bit_q, bit_d, nb;
  logic [31:0] frame_q, frame_d;
  logic        rd_q, rd_d;
  logic        mdo_q, mdo_d;
  logic        mdt_q, mdt_d;
  logic [15:0] rsh_q, rsh_d;
  logic [15:0] rdata_q, rdata_d;
  logic        acc, en, fall, last;
  logic        unused_rise;
  logic        unused_wr;

  assign unused_wr   = ^hostwrdata[31:16];
  assign hostmiimrdy = (state_q == S_IDLE);
  assign acc         = hostreq && hostmiimsel &&
                       hostmiimrdy && op_ok;
  assign last        = (state_q == S_DATA) && (bit_q == 6'd0);
  assign en          = (state_q inside {S_PRE, S_HDR, S_TA, S_DATA})
                       && !last;
  assign nb          = bit_q + 6'd1;
  assign hostrddata  = {16'b0, rdata_q};
  assign mdio_o      = mdo_q;
  assign mdio_t      = mdt_q;

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_n_i),
    .en_i   (en),
    .mdc_o  (mdc),
    .rise_o (unused_rise),
    .fall_o (fall)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    rd_d    = rd_q;
    mdo_d   = mdo_q;
    mdt_d   = mdt_q;
    rsh_d   = rsh_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          state_d = S_PRE;
          bit_d   = 6'd0;
          frame_d = {ST_SEL, hostopcode, hostaddr,
                     TA_WR, hostwrdata[15:0]};
          rd_d    = hostopcode[1];
          mdo_d   = 1'b1;
          mdt_d   = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (last) begin
          state_d = S_DONE;
          if (rd_q) rdata_d = rsh_q;
        end else if (fall) begin
          if (rd_q && bit_q >= DATA_START)
            rsh_d = {rsh_q[14:0], mdio_i};
          bit_d = nb;
          // bit counter wraps to 0 after the last DATA bit
          if (nb == 6'd0)            state_d = S_DATA;
          else if (nb < PRE_LEN)     state_d = S_PRE;
          else if (nb < HDR_END)     state_d = S_HDR;
          else if (nb < DATA_START)  state_d = S_TA;
          else                       state_d = S_DATA;
          if (nb == 6'd0 || (rd_q && nb >= HDR_END)) begin
            mdo_d = 1'b1;
            mdt_d = 1'b1;
          end else begin
            mdt_d = 1'b0;
            mdo_d = (nb < PRE_LEN) ? 1'b1 : frame_q[~nb[4:0]];
          end
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      bit_q   <= 6'd0;
      frame_q <= 32'd0;
      rd_q    <= 1'b0;
      mdo_q   <= 1'b1;
      mdt_q   <= 1'b1;
      rsh_q   <= 16'd0;
      rdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      rd_q    <= rd_d;
      mdo_q   <= mdo_d;
      mdt_q   <= mdt_d;
      rsh_q   <= rsh_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mdio_host_master.sv
// Directed bench for mdio_host_master with CLK_DIV=4 and a PHY model.
// Expectations follow MDIO_CLAUSE45_EN when the bench is built with it.
module tb_mdio_host_master;
  import mdio_pkg::*;

  localparam int D   = 4;
  localparam int LAT = 128 * D + 2;
`ifdef MDIO_CLAUSE45_EN
  localparam logic [1:0] ST_EXP = 2'b00;
`else
  localparam logic [1:0] ST_EXP = 2'b01;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hostreq = 1'b0;
  logic        hostmiimsel = 1'b0;
  logic [1:0]  hostopcode = 2'b00;
  logic [9:0]  hostaddr = 10'd0;
  logic [31:0] hostwrdata = 32'd0;
  logic [31:0] hostrddata;
  logic        hostmiimrdy;
  logic        mdc, mdio_o, mdio_t, mdio_i;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int n;

  logic [63:0] cap, capt;
  logic [6:0]  idx = 7'd0;
  logic [6:0]  nbits = 7'd0;
  logic        mdc_p = 1'b0;
  logic [15:0] phy_val = 16'hBEEF;

  always #5 clk = ~clk;

  mdio_host_master #(.CLK_DIV(D)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .hostreq     (hostreq),
    .hostmiimsel (hostmiimsel),
    .hostopcode  (hostopcode),
    .hostaddr    (hostaddr),
    .hostwrdata  (hostwrdata),
    .hostrddata  (hostrddata),
    .hostmiimrdy (hostmiimrdy),
    .mdc         (mdc),
    .mdio_o      (mdio_o),
    .mdio_t      (mdio_t),
    .mdio_i      (mdio_i)
  );

  // PHY model: drives data bit k while mdc is high in frame bit 48+k
  assign mdio_i = (idx >= 7'd49 && idx <= 7'd64) ?
                  phy_val[4'(64 - int'(idx))] : 1'b1;

  always @(posedge clk) begin
    mdc_p <= mdc;
    if (hostmiimrdy) begin
      if (idx != 7'd0) nbits <= idx;
      idx <= 7'd0;
    end else if (mdc && !mdc_p) begin
      if (idx < 7'd64) begin
        cap[63 - int'(idx)]  <= mdio_o;
        capt[63 - int'(idx)] <= mdio_t;
      end
      idx <= idx + 7'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic sel, input logic [1:0] op,
                      input logic [9:0] ad, input logic [31:0] wd);
    @(negedge clk);
    hostreq     = 1'b1;
    hostmiimsel = sel;
    hostopcode  = op;
    hostaddr    = ad;
    hostwrdata  = wd;
    @(negedge clk);
    hostreq = 1'b0;
    lat = 0;
  endtask

  task automatic wait_rdy(input int limit);
    while (!hostmiimrdy && lat < limit) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'(hostmiimrdy), 64'd1);
    chk("rst_mdc", 64'(mdc), 64'd0);
    chk("rst_mdio_o", 64'(mdio_o), 64'd1);
    chk("rst_mdio_t", 64'(mdio_t), 64'd1);
    chk("rst_rddata", 64'(hostrddata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // write to PHY 3, reg 5
    send(1'b1, 2'b01, 10'b00011_00101, 32'hDEAD_1234);
    chk("wr_rdy_low", 64'(hostmiimrdy), 64'd0);
    wait_rdy(2000);
    chk("wr_latency", 64'(lat), 64'(LAT));
    @(negedge clk);
    chk("wr_nbits", 64'(nbits), 64'(FRAME_LEN));
    chk("wr_serial", cap,
        {32'hFFFF_FFFF, ST_EXP, 2'b01, 10'b00011_00101,
         2'b10, 16'h1234});
    chk("wr_tristate", capt, 64'd0);
    chk("wr_rddata", 64'(hostrddata), 64'd0);

    // read PHY 1, reg 2; PHY answers 0xBEEF
    send(1'b1, 2'b10, 10'b00001_00010, 32'h0);
    wait_rdy(LAT - 2);
    chk("rd_pre_done", 64'(hostrddata), 64'd0);
    @(negedge clk);
    chk("rd_done_data", 64'(hostrddata), 64'h0000_BEEF);
    chk("rd_done_rdy", 64'(hostmiimrdy), 64'd0);
    @(negedge clk);
    chk("rd_rdy_next", 64'(hostmiimrdy), 64'd1);
    @(negedge clk);
    chk("rd_nbits", 64'(nbits), 64'(FRAME_LEN));
    chk("rd_hdr", 64'(cap[63:18]),
        64'({32'hFFFF_FFFF, ST_EXP, 2'b10, 10'b00001_00010}));
    chk("rd_tristate", capt, 64'h0000_0000_0003_FFFF);

    // ignored requests: sel=0 while idle, then a pulse mid-frame
    send(1'b0, 2'b01, 10'b00011_00101, 32'h5555);
    chk("nosel_rdy", 64'(hostmiimrdy), 64'd1);
    send(1'b1, 2'b01, 10'b00111_11000, 32'h00FF);
    wait_rdy(100);
    send(1'b1, 2'b10, 10'b11111_11111, 32'hFFFF);
    lat = 102;
    wait_rdy(2000);
    chk("mid_latency", 64'(lat), 64'(LAT));
    @(negedge clk);
    chk("mid_serial", cap,
        {32'hFFFF_FFFF, ST_EXP, 2'b01, 10'b00111_11000,
         2'b10, 16'h00FF});
    chk("mid_rddata", 64'(hostrddata), 64'h0000_BEEF);

    // reset during bit 40 of a read
    send(1'b1, 2'b10, 10'b00001_00010, 32'h0);
    n = 0;
    while (idx != 7'd41 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", 64'(idx), 64'd41);
    rst_n = 1'b0;
    #1;
    chk("abort_mdc", 64'(mdc), 64'd0);
    chk("abort_t", 64'(mdio_t), 64'd1);
    chk("abort_rdy", 64'(hostmiimrdy), 64'd1);
    chk("abort_rddata", 64'(hostrddata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b1, 2'b01, 10'b00011_00101, 32'h0000_1234);
    wait_rdy(2000);
    chk("post_latency", 64'(lat), 64'(LAT));
    @(negedge clk);
    chk("post_nbits", 64'(nbits), 64'(FRAME_LEN));
    chk("post_serial", cap,
        {32'hFFFF_FFFF, ST_EXP, 2'b01, 10'b00011_00101,
         2'b10, 16'h1234});

    // opcode 00: C45 address frame or ignored in C22 mode
    send(1'b1, 2'b00, 10'b00011_00101, 32'h0000_A5A5);
`ifdef MDIO_CLAUSE45_EN
    wait_rdy(2000);
    chk("c45_latency", 64'(lat), 64'(LAT));
    @(negedge clk);
    chk("c45_serial", cap,
        {32'hFFFF_FFFF, 2'b00, 2'b00, 10'b00011_00101,
         2'b10, 16'hA5A5});
    chk("c45_tristate", capt, 64'd0);
`else
    repeat (20) begin
      @(negedge clk);
      chk("c22_op00_rdy", 64'(hostmiimrdy), 64'd1);
      chk("c22_op00_t", 64'(mdio_t), 64'd1);
    end
    send(1'b1, 2'b11, 10'b00011_00101, 32'h0000_A5A5);
    @(negedge clk);
    chk("c22_op11_rdy", 64'(hostmiimrdy), 64'd1);
    chk("c22_op11_mdc", 64'(mdc), 64'd0);
`endif
    chk("final_rddata", 64'(hostrddata), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
